mdu_unit: RTL and testbench

Multiply/divide unit in the Execute stage of the 5-stage pipeline. It runs mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO architectural registers. It serves mfhi/mflo reads and mthi/mtlo writes. Its busy output and the E-stage start pulse feed the hazard unit, which stalls D-stage MD instructions while an operation is in flight.

---
 rtl/mdu_unit.sv | 157 +++++++++++++++
 tb/tb_mdu_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with the HI/LO architectural registers.
// Results are computed from latched operands and committed on the final busy cycle.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;

    logic              is_mul_op, is_start_op;
    logic              sx_mul, neg_a, neg_b;
    logic [63:0]       mul_a, mul_b, product;
    logic [31:0]       mag_a, mag_b, uq, ur, quot, rem;

    // A single 64-bit multiplier serves both flavours; only the operand extension differs.
    always_comb begin
        sx_mul  = (op_q == OP_MULT);
        mul_a   = {{32{sx_mul & a_q[31]}}, a_q};
        mul_b   = {{32{sx_mul & b_q[31]}}, b_q};
        product = mul_a * mul_b;
    end

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        neg_a = (op_q == OP_DIV) && a_q[31];
        neg_b = (op_q == OP_DIV) && b_q[31];
        mag_a = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b = neg_b ? (~b_q + 32'd1) : b_q;
        uq    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
        ur    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;
        quot  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem   = neg_a ? (~ur + 32'd1) : ur;
    end

    assign is_mul_op   = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    assign is_start_op = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start && !Req && is_start_op) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    op_d    = MDOp;
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (!Req && MDOp == OP_MTHI) begin
                    hi_d = A;
                end else if (!Req && MDOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        hi_d = product[63:32];
                        lo_d = product[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand latches are reset along with HI/LO so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (MDOp == OP_MFHI) MDOut = hi_q;
        else if (MDOp == OP_MFLO) MDOut = lo_q;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: a high-level arithmetic model predicts HI/LO and latency,
// and an independent monitor checks each commit when busy falls.
module tb_mdu_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A, B;
    logic        Req;
    logic        busy;
    logic [31:0] HI, LO, MDOut;

    mdu_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .Req(Req), .busy(busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers; divide by zero leaves the model untouched.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r, p;
        longint unsigned ua, ub, uq, ur, up;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            4'd1: begin p = sa * sb_; model_hi = p[63:32]; model_lo = p[31:0]; end
            4'd2: begin up = ua * ub; model_hi = up[63:32]; model_lo = up[31:0]; end
            4'd3: if (b != 0) begin
                q = sa / sb_; r = sa % sb_;
                model_lo = q[31:0]; model_hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                uq = ua / ub; ur = ua % ub;
                model_lo = uq[31:0]; model_hi = ur[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Issue a mult/div; with req set it must be ignored and nothing is expected.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        exp_t e;
        @(negedge clk);
        if (!req) begin
            model_op(op, a, b);
            e.hi = model_hi;
            e.lo = model_lo;
            e.cycles = (op <= 4'd2) ? MULT_CYCLES : DIV_CYCLES;
            sb.push_back(e);
        end
        start = 1'b1; MDOp = op; A = a; B = b; Req = req;
        @(negedge clk);
        start = 1'b0; MDOp = 4'd0; Req = 1'b0;
        if (req) begin
            check("req_no_busy", {31'd0, busy}, 32'd0);
            check("req_hi", HI, model_hi);
            check("req_lo", LO, model_lo);
        end else begin
            wait_idle();
        end
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input logic req);
        @(negedge clk);
        MDOp = op; A = a; Req = req;
        if (!req) begin
            if (op == 4'd7) model_hi = a;
            else model_lo = a;
        end
        @(negedge clk);
        MDOp = 4'd0; Req = 1'b0;
        check("mt_hi", HI, model_hi);
        check("mt_lo", LO, model_lo);
    endtask

    task automatic do_read(input logic [3:0] op);
        @(negedge clk);
        MDOp = op;
        #1;
        if (op == 4'd5) check("mfhi", MDOut, model_hi);
        else if (op == 4'd6) check("mflo", MDOut, model_lo);
        else check("mdout_zero", MDOut, 32'd0);
        MDOp = 4'd0;
    endtask

    // Monitor: counts busy cycles and checks the committed HI/LO when busy falls.
    initial begin
        int   busy_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(busy_cnt), 32'(e.cycles));
                    check("commit_hi", HI, e.hi);
                    check("commit_lo", LO, e.lo);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; MDOp = 4'd0; A = '0; B = '0; Req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b1;

        // Reset in the middle of an operation discards it and clears HI/LO.
        do_mt(4'd7, 32'hAB, 1'b0);
        @(negedge clk);
        start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; MDOp = 4'd0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        model_hi = 32'd0; model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        do_read(4'd5);

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(4'd4, 32'd7, 32'd2, 1'b0);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_read(4'd5);
        do_read(4'd6);

        do_mt(4'd7, 32'h11, 1'b0);
        do_mt(4'd8, 32'h22, 1'b0);
        do_op(4'd4, 32'd5, 32'd0, 1'b0);
        do_op(4'd3, 32'hFFFF_FF00, 32'd0, 1'b0);

        do_op(4'd1, 32'd9, 32'd9, 1'b1);
        do_mt(4'd8, 32'h55, 1'b1);

        // Req raised on the second busy cycle must not disturb the running multiply.
        begin
            exp_t e;
            @(negedge clk);
            model_op(4'd1, 32'd6, 32'd7);
            e.hi = model_hi; e.lo = model_lo; e.cycles = MULT_CYCLES;
            sb.push_back(e);
            start = 1'b1; MDOp = 4'd1; A = 32'd6; B = 32'd7;
            @(negedge clk);
            start = 1'b0; MDOp = 4'd0;
            @(negedge clk);
            Req = 1'b1; MDOp = 4'd8; A = 32'hDEAD_BEEF;
            @(negedge clk);
            Req = 1'b0; MDOp = 4'd0;
            wait_idle();
            check("req_run_lo", LO, 32'd42);
        end

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
            if (op <= 4'd4) do_op(op, ra, rb, 1'b0);
            else do_mt((op == 4'd5) ? 4'd7 : 4'd8, ra, 1'b0);
            do_read(4'($urandom_range(5, 6)));
        end
        do_read(4'd9);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
